// File: rtl/tick_rate_scheduler_if.sv
// rtl/tick_rate_scheduler_if.sv - rate-request valid/ready handshake between mode-select logic and the scheduler
interface tick_rate_scheduler_if;
    logic [7:0] selector;
    logic       sel_valid;
    logic       sel_ready;

    modport master (
        output selector,
        output sel_valid,
        input  sel_ready
    );

    modport slave (
        input  selector,
        input  sel_valid,
        output sel_ready
    );
endinterface

// File: rtl/tick_rate_scheduler.sv
// rtl/tick_rate_scheduler.sv - run/stop and rate-switching controller for the selectable slow-clock divider
// TICK_SCHED_SYNC_SWITCH_EN: defer rate switches to the next half-period boundary via a PEND state
module tick_rate_scheduler #(
    parameter int HALF_FAST = 10000,
    parameter int HALF_MID  = 25000000,
    parameter int HALF_SLOW = 50000000,
    parameter int CNT_W     = 26
) (
    input  logic                       clkin,
    input  logic                       rst,
    tick_rate_scheduler_if.slave       sel,
    input  logic                       start,
    input  logic                       stop,
    output logic                       clkout,
    output logic                       tick,
    output logic [1:0]                 rate,
    output logic                       busy
);

    localparam logic [CNT_W-1:0] TC_FAST = CNT_W'(HALF_FAST - 1);
    localparam logic [CNT_W-1:0] TC_MID  = CNT_W'(HALF_MID - 1);
    localparam logic [CNT_W-1:0] TC_SLOW = CNT_W'(HALF_SLOW - 1);

`ifdef TICK_SCHED_SYNC_SWITCH_EN
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PEND = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic [1:0]       rate_q, rate_d;
`ifdef TICK_SCHED_SYNC_SWITCH_EN
    logic [1:0]       pend_q, pend_d;
`endif

    logic       accept;
    logic       tc;
    logic [1:0] req_rate;

    function automatic logic [1:0] decode_rate(input logic [7:0] code);
        case (code)
            8'd16:   decode_rate = 2'd1;
            8'd48:   decode_rate = 2'd2;
            default: decode_rate = 2'd0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] term_of(input logic [1:0] r);
        case (r)
            2'd1:    term_of = TC_MID;
            2'd2:    term_of = TC_SLOW;
            default: term_of = TC_FAST;
        endcase
    endfunction

`ifdef TICK_SCHED_SYNC_SWITCH_EN
    assign sel.sel_ready = (state_q != PEND);
`else
    assign sel.sel_ready = 1'b1;
`endif

    assign accept   = sel.sel_valid && sel.sel_ready;
    assign req_rate = decode_rate(sel.selector);
    assign tc       = (cnt_q == term_of(rate_q));

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
            tick_q  <= 1'b0;
            rate_q  <= 2'd0;
`ifdef TICK_SCHED_SYNC_SWITCH_EN
            pend_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
            rate_q  <= rate_d;
`ifdef TICK_SCHED_SYNC_SWITCH_EN
            pend_q  <= pend_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;
        rate_d  = rate_q;
`ifdef TICK_SCHED_SYNC_SWITCH_EN
        pend_d  = pend_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (accept) begin
                    rate_d = req_rate;
                end
                if (start && !stop) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                end else begin
                    if (tc) begin
                        cnt_d  = '0;
                        clk_d  = ~clk_q;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (accept && (req_rate != rate_q)) begin
`ifdef TICK_SCHED_SYNC_SWITCH_EN
                        // A coincident boundary still toggles at the old rate; the switch waits for the next one.
                        pend_d  = req_rate;
                        state_d = PEND;
`else
                        rate_d = req_rate;
                        cnt_d  = '0;
                        clk_d  = clk_q;
                        tick_d = 1'b0;
`endif
                    end
                end
            end
`ifdef TICK_SCHED_SYNC_SWITCH_EN
            PEND: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    clk_d   = 1'b0;
                    pend_d  = 2'd0;
                end else if (tc) begin
                    cnt_d   = '0;
                    clk_d   = ~clk_q;
                    tick_d  = 1'b1;
                    rate_d  = pend_q;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                clk_d   = 1'b0;
            end
        endcase
    end

    assign clkout = clk_q;
    assign tick   = tick_q;
    assign rate   = rate_q;
    assign busy   = (state_q != IDLE);

endmodule
